// File: rtl/uart_tx_pkg.sv
// Shared types for the UART transmit arbiter: FSM states, byte-select codes
// and the grant-index width helper.
// Imported by uart_tx_arbiter and rr_arbiter.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    GAP
  } state_t;

  // Which half of the latched package goes out on the next start.
  localparam logic HI = 1'b0;
  localparam logic LO = 1'b1;

  // Width of a requester index; never below one bit.
  function automatic int gid_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: the first valid requester after ptr, wrapping at N_REQ.
// Purely combinational, zero latency.
// No backpressure; any is low when no requester is valid.
module rr_arbiter
  import uart_tx_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]            req,
  input  logic [gid_width(N_REQ)-1:0] ptr,
  output logic                        any,
  output logic [N_REQ-1:0]            onehot,
  output logic [gid_width(N_REQ)-1:0] idx
);

  localparam int GW = gid_width(N_REQ);

  logic [N_REQ-1:0] rot;
  int               pos;

  // Rotate so bit 0 is the requester after ptr, then take the lowest set bit
  always_comb begin
    rot = N_REQ'({req, req} >> (int'(ptr) + 1));
    any = |rot;
    pos = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) pos = int'(ptr) + 1 + i;
    end
    if (pos >= N_REQ) pos = pos - N_REQ;
    idx    = GW'(pos);
    onehot = any ? (N_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ 16-bit sources, sending HI then LO byte.
// Grant to tx_start_o is 2 clocks; each frame is followed by GAP_CYCLES idle clocks.
// Holds in ISSUE until tx_rts_i is high; sets sticky err_o if a start is never acknowledged.
// Build option UART_TX_ERR_INJECT_EN adds inject_i, which flips ERR_MASK bits in the LO byte.
module uart_tx_arbiter
  import uart_tx_pkg::*;
#(
  parameter int         N_REQ       = 2,
  parameter int         GAP_CYCLES  = 16,
  parameter int         ACK_TIMEOUT = 1024,
  parameter logic [7:0] ERR_MASK    = 8'b01000100
) (
  input  logic                        CLK_i,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [16*N_REQ-1:0]         req_word_i,
`ifdef UART_TX_ERR_INJECT_EN
  input  logic                        inject_i,
`endif
  output logic [N_REQ-1:0]            req_ready_o,
  output logic [7:0]                  tx_data_o,
  output logic                        tx_start_o,
  input  logic                        tx_rts_i,
  output logic [gid_width(N_REQ)-1:0] grant_id_o,
  output logic                        busy_o,
  output logic                        err_o
);

  localparam int GW  = gid_width(N_REQ);
  localparam int TW  = $clog2(ACK_TIMEOUT + 1);
  localparam int GCW = $clog2(GAP_CYCLES + 2);

  state_t           state, state_nxt;
  logic             byte_sel;
  logic [GW-1:0]    rr_ptr;
  logic [TW-1:0]    tmo_cnt;
  logic [GCW-1:0]   gap_cnt;
  logic [15:0]      word_q;
  logic [15:0]      word_sel;
  logic [7:0]       lo_byte;
  logic [7:0]       frame;

  logic             arb_any;
  logic [N_REQ-1:0] arb_onehot;
  logic [GW-1:0]    arb_idx;

  logic             take;
  logic             issue;
  logic             tmo_hit;
  logic             gap_done;

`ifdef UART_TX_ERR_INJECT_EN
  logic             inj_q;
`else
  logic             unused_mask;
  assign unused_mask = ^ERR_MASK;
`endif

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .req    (req_valid_i),
    .ptr    (rr_ptr),
    .any    (arb_any),
    .onehot (arb_onehot),
    .idx    (arb_idx)
  );

  assign busy_o = (state != IDLE);

  // State register
  always_ff @(posedge CLK_i or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (arb_any) state_nxt = ISSUE;
      ISSUE:     if (tx_rts_i) state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (!tx_rts_i)    state_nxt = WAIT_DONE;
        else if (tmo_hit) state_nxt = IDLE;
      end
      WAIT_DONE: if (tx_rts_i) state_nxt = GAP;
      GAP:       if (gap_done) state_nxt = (byte_sel == HI) ? ISSUE : IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Control decode and frame byte selection
  always_comb begin
    take     = (state == IDLE) && arb_any;
    issue    = (state == ISSUE) && tx_rts_i;
    tmo_hit  = (state == WAIT_ACK) && tx_rts_i && (tmo_cnt == TW'(ACK_TIMEOUT - 1));
    gap_done = (state == GAP) && (gap_cnt == GCW'(GAP_CYCLES));
    word_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_onehot[i]) word_sel = req_word_i[16*i +: 16];
    end
    lo_byte = word_q[7:0];
`ifdef UART_TX_ERR_INJECT_EN
    if (inj_q) lo_byte = word_q[7:0] ^ ERR_MASK;
`endif
    frame = (byte_sel == HI) ? word_q[15:8] : lo_byte;
  end

  // Datapath, counters and registered outputs
  always_ff @(posedge CLK_i or posedge reset) begin
    if (reset) begin
      byte_sel    <= HI;
      rr_ptr      <= GW'(N_REQ - 1);
      tmo_cnt     <= '0;
      gap_cnt     <= '0;
      word_q      <= '0;
      req_ready_o <= '0;
      tx_data_o   <= '0;
      tx_start_o  <= 1'b0;
      grant_id_o  <= '0;
      err_o       <= 1'b0;
    end else begin
      req_ready_o <= take ? arb_onehot : '0;
      tx_start_o  <= issue;
      if (take) begin
        word_q     <= word_sel;
        grant_id_o <= arb_idx;
        rr_ptr     <= arb_idx;
      end
      if (issue) begin
        tx_data_o <= frame;
        tmo_cnt   <= '0;
      end
      if (state == WAIT_ACK) tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_hit) begin
        err_o    <= 1'b1;
        byte_sel <= HI;
      end
      if ((state == WAIT_DONE) && tx_rts_i) gap_cnt <= '0;
      if (state == GAP) begin
        if (gap_done) byte_sel <= ~byte_sel;
        else          gap_cnt  <= gap_cnt + 1'b1;
      end
    end
  end

`ifdef UART_TX_ERR_INJECT_EN
  // Injection request is captured with the package it applies to
  always_ff @(posedge CLK_i or posedge reset) begin
    if (reset)     inj_q <= 1'b0;
    else if (take) inj_q <= inject_i;
  end
`endif

endmodule
